// File: rtl/clock_time_core.sv
// Digital clock timekeeping core: BCD HH:MM:SS.cc counter, button-driven set mode,
// blinking decimal points for the field being edited.
module clock_time_field #(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] units
);
  localparam logic [3:0] LT = 4'((MOD - 1) / 10);
  localparam logic [3:0] LU = 4'((MOD - 1) % 10);

  logic at_max, at_zero;
  assign at_max  = (tens == LT) && (units == LU);
  assign at_zero = (tens == 4'd0) && (units == 4'd0);

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (units == 4'd9) begin
        tens  <= tens + 4'd1;
        units <= 4'd0;
      end else begin
        units <= units + 4'd1;
      end
    end else if (dec) begin
      if (at_zero) begin
        tens  <= LT;
        units <= LU;
      end else if (units == 4'd0) begin
        tens  <= tens - 4'd1;
        units <= 4'd9;
      end else begin
        units <= units - 4'd1;
      end
    end
  end
endmodule

module clock_time_core #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] led1Number,
  output logic [3:0] led2Number,
  output logic [3:0] led3Number,
  output logic [3:0] led4Number,
  output logic [3:0] led5Number,
  output logic [3:0] led6Number,
  output logic [3:0] led7Number,
  output logic [3:0] led8Number,
  output logic [7:0] point,
  output logic [1:0] mode
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10, SET_SEC = 2'b11} state_t;

  localparam int NF = 4;  // fields: 0 cc, 1 SS, 2 MM, 3 HH
  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0] PT_RUN = 8'b1010_1011;

  state_t state, state_nx;
  logic [PW-1:0] pre;
  logic [BW-1:0] bcnt;
  logic blink, blink_nx;
  logic tick, edit;
  logic [7:0] point_nx;
  logic [NF-1:0] sel, carry, f_inc, f_dec, f_clr;
  logic [NF-1:0][3:0] f_tens, f_units;

  assign tick  = (state == RUN) && (pre == PW'(TICK_DIV - 1));
  assign edit  = (state != RUN) && !btn_mode && (btn_up ^ btn_down);
  assign blink_nx = (bcnt == BW'(BLINK_DIV - 1)) ? ~blink : blink;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sel      = '0;
    case (state)
      RUN:      if (btn_mode) state_nx = SET_HOUR;
      SET_HOUR: begin sel[3] = 1'b1; if (btn_mode) state_nx = SET_MIN; end
      SET_MIN:  begin sel[2] = 1'b1; if (btn_mode) state_nx = SET_SEC; end
      SET_SEC:  begin sel[1] = 1'b1; if (btn_mode) state_nx = RUN;     end
      default:  state_nx = RUN;
    endcase
  end

  // A tick coinciding with btn_mode is dropped; prescaler restarts from 0 on return to RUN.
  always_ff @(posedge clk) begin
    if (!reset_n || state != RUN || btn_mode || tick) pre <= '0;
    else                                              pre <= pre + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else begin
      bcnt  <= (bcnt == BW'(BLINK_DIV - 1)) ? '0 : bcnt + BW'(1);
      blink <= blink_nx;
    end
  end

  assign carry[0] = tick && !btn_mode;

  for (genvar i = 0; i < NF; i++) begin : g_fld
    localparam int MOD = (i == 0) ? 100 : (i == NF - 1) ? 24 : 60;
    if (i > 0) begin : g_cy
      localparam int PMOD = (i == 1) ? 100 : 60;
      assign carry[i] = carry[i-1] && (f_tens[i-1] == 4'((PMOD - 1) / 10))
                                   && (f_units[i-1] == 4'((PMOD - 1) % 10));
    end
    assign f_inc[i] = carry[i] | (sel[i] & edit & btn_up);
    assign f_dec[i] = sel[i] & edit & btn_down;
    assign f_clr[i] = (i == 0) && (state == RUN) && btn_mode;

    clock_time_field #(.MOD(MOD)) u_fld (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (f_clr[i]),
      .inc     (f_inc[i]),
      .dec     (f_dec[i]),
      .tens    (f_tens[i]),
      .units   (f_units[i])
    );
  end

  // Register the points from next state/blink so they line up with mode.
  always_comb begin
    point_nx = PT_RUN;
    case (state_nx)
      SET_HOUR: point_nx[7:6] = {2{~blink_nx}};
      SET_MIN:  point_nx[5:4] = {2{~blink_nx}};
      SET_SEC:  point_nx[3:2] = {2{~blink_nx}};
      default:  point_nx = PT_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) point <= PT_RUN;
    else          point <= point_nx;
  end

  assign mode       = state;
  assign led1Number = f_units[0];
  assign led2Number = f_tens[0];
  assign led3Number = f_units[1];
  assign led4Number = f_tens[1];
  assign led5Number = f_units[2];
  assign led6Number = f_tens[2];
  assign led7Number = f_units[3];
  assign led8Number = f_tens[3];
endmodule
